// File: rtl/sobel_pkg.sv
// Shared types and arithmetic for the Sobel 3x3 edge filter.
package sobel_pkg;

    localparam int unsigned PIX_W  = 4;
    localparam int unsigned GRAD_W = 8;
    localparam int unsigned MAG_W  = 7;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    // Window element (r,c) lives at index r*3+c; row 0 is the oldest line, col 0 the oldest column.
    typedef logic [8:0][PIX_W-1:0] window_t;

    function automatic logic [MAG_W-1:0] sobel_mag(input window_t w);
        logic signed [GRAD_W-1:0] p [9];
        logic signed [GRAD_W-1:0] gx;
        logic signed [GRAD_W-1:0] gy;
        logic        [GRAD_W-1:0] ax;
        logic        [GRAD_W-1:0] ay;
        logic        [GRAD_W-1:0] sum;
        for (int unsigned i = 0; i < 9; i++) begin
            p[i] = signed'(GRAD_W'(w[i]));
        end
        gx  = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
        gy  = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
        ax  = (gx < 0) ? GRAD_W'(-gx) : GRAD_W'(gx);
        ay  = (gy < 0) ? GRAD_W'(-gy) : GRAD_W'(gy);
        sum = ax + ay;
        return sum[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_window_filter_if.sv
// Pixel-in / edge-out stream bundle for sobel_window_filter.
interface sobel_window_filter_if #(
    parameter int unsigned PIX_W = sobel_pkg::PIX_W
);
    logic             pix_valid;
    logic             pix_sof;
    logic [PIX_W-1:0] pix_in;
    logic             edge_valid;
    logic [PIX_W-1:0] edge_out;
    logic             edge_eof;

    modport master (
        output pix_valid, pix_sof, pix_in,
        input  edge_valid, edge_out, edge_eof
    );

    modport slave (
        input  pix_valid, pix_sof, pix_in,
        output edge_valid, edge_out, edge_eof
    );
endinterface

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: synchronous write, asynchronous read at the same address.
module sobel_line_buffer #(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned PIX_W = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(IMG_W)-1:0] addr,
    input  logic [PIX_W-1:0]         wr_data,
    output logic [PIX_W-1:0]         rd_data
);

    logic [PIX_W-1:0] mem [IMG_W];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_filter.sv
// Sobel |Gx|+|Gy| edge filter over a raster stream, two line buffers, 2-cycle latency.
// Optional build macro SOBEL_THRESH_EN: binary edge map against thresh_in.
module sobel_window_filter
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_W = 320,
    parameter int unsigned IMG_H = 240
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
`ifdef SOBEL_THRESH_EN
    input  logic [MAG_W-1:0]      thresh_in,
`endif
    sobel_window_filter_if.slave  bus
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [CW-1:0]    cur_col;
    logic [RW-1:0]    cur_row;
    logic             accept;
    logic             last_pix;
    logic             emit;
    logic             emit_q;
    logic             eof_q;
    window_t          win_q;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;
    logic [MAG_W-1:0] mag;

    sobel_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (bus.pix_in),
        .rd_data (lb0_rd)
    );

    sobel_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (cur_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // An SOF pixel always lands at (0,0), whether the FSM is idle or mid-frame.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        cur_row = row_q;
        cur_col = col_q;
        if (bus.pix_valid) begin
            if (bus.pix_sof) begin
                accept  = 1'b1;
                cur_row = '0;
                cur_col = '0;
            end else if (state_q == ACTIVE) begin
                accept = 1'b1;
            end
        end
        last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
        emit     = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        if (accept) begin
            state_d = last_pix ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (accept) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= last_pix ? '0 : cur_row + RW'(1);
            end else begin
                col_q <= cur_col + CW'(1);
                row_q <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            emit_q <= 1'b0;
            eof_q  <= 1'b0;
        end else begin
            emit_q <= emit;
            eof_q  <= accept && last_pix;
            if (accept) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= lb1_rd;
                win_q[3] <= win_q[4];
                win_q[4] <= win_q[5];
                win_q[5] <= lb0_rd;
                win_q[6] <= win_q[7];
                win_q[7] <= win_q[8];
                win_q[8] <= bus.pix_in;
            end
        end
    end

    assign mag = sobel_mag(win_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.edge_valid <= 1'b0;
            bus.edge_out   <= '0;
            bus.edge_eof   <= 1'b0;
        end else begin
            bus.edge_valid <= emit_q;
            bus.edge_eof   <= eof_q;
`ifdef SOBEL_THRESH_EN
            bus.edge_out   <= (mag >= thresh_in) ? '1 : '0;
`else
            bus.edge_out   <= mag[MAG_W-1 -: PIX_W];
`endif
        end
    end

    assign busy = (state_q == ACTIVE);

endmodule

// File: tb/tb_sobel_window_filter.sv
// Randomized bench for sobel_window_filter (8x6 image) against a 2-D image reference model.
module tb_sobel_window_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int THRESH = 40;

    typedef struct {
        int val;
        bit eof;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef SOBEL_THRESH_EN
    logic [6:0] thresh_in = 7'(THRESH);
`endif

    sobel_window_filter_if #(.PIX_W(4)) bus ();

    sobel_window_filter #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy),
`ifdef SOBEL_THRESH_EN
        .thresh_in (thresh_in),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_out    = 0;
    exp_t exp_q [$];

    int img [H][W];
    bit m_active = 1'b0;
    int m_row = 0;
    int m_col = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected output for the window whose bottom-right pixel is (r,c).
    function automatic int ref_edge(input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESH_EN
        return (mag >= THRESH) ? 15 : 0;
`else
        return mag / 8;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.edge_valid) n_out++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("edge_valid", 32'(bus.edge_valid), 32'd1);
                check_eq("edge_out", 32'(bus.edge_out), 32'(e.val));
                check_eq("edge_eof", 32'(bus.edge_eof), 32'(e.eof));
            end else if (bus.edge_valid || bus.edge_eof) begin
                check_eq("spurious_valid", 32'(bus.edge_valid | bus.edge_eof), 32'd0);
            end
        end
    end

    // Drive one cycle (called just after a rising edge) and update the model for its acceptance.
    task automatic drive(input bit v, input bit sof, input int pix);
        bit acc;
        int r, c;
        bus.pix_valid = v;
        bus.pix_sof   = sof;
        bus.pix_in    = pix[3:0];
        acc = 1'b0;
        if (v && sof) begin
            acc = 1'b1; m_active = 1'b1; m_row = 0; m_col = 0;
        end else if (v && m_active) begin
            acc = 1'b1;
        end
        if (acc) begin
            r = m_row; c = m_col;
            img[r][c] = pix & 15;
            if (r >= 2 && c >= 2) begin
                exp_q.push_back('{val: ref_edge(r, c), eof: (r == H-1 && c == W-1), cyc: cyc + 2});
            end
            if (c == W-1) begin
                m_col = 0;
                if (r == H-1) begin
                    m_row = 0; m_active = 1'b0;
                end else begin
                    m_row = r + 1;
                end
            end else begin
                m_col = c + 1;
            end
        end
        @(posedge clk); #1;
        check_eq("busy", 32'(busy), 32'(m_active));
    endtask

    // kind: 0 const 9, 1 vertical step, 2 random. gaps: 0 none, 1 alternate, 2 random.
    task automatic send_frame(input int kind, input int gaps, input int npix);
        int pix;
        for (int i = 0; i < npix; i++) begin
            case (kind)
                0:       pix = 9;
                1:       pix = ((i % W) >= 4) ? 15 : 0;
                default: pix = int'($urandom_range(0, 15));
            endcase
            drive(1'b1, (i == 0), pix);
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 3) == 0)) begin
                drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_edge_valid", 32'(bus.edge_valid), 32'd0);
        check_eq("rst_edge_out", 32'(bus.edge_out), 32'd0);
        check_eq("rst_edge_eof", 32'(bus.edge_eof), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        n_out = 0; send_frame(0, 0, W*H); drain();
        check_eq("const_count", 32'(n_out), 32'd24);

        n_out = 0; send_frame(1, 0, W*H); drain();
        check_eq("step_count", 32'(n_out), 32'd24);

        n_out = 0; send_frame(1, 1, W*H); drain();
        check_eq("toggle_count", 32'(n_out), 32'd24);

        // Restart at (3,5): 9 outputs of the old frame plus a full new frame.
        n_out = 0; send_frame(2, 0, 3*W + 5); send_frame(2, 2, W*H); drain();
        check_eq("restart_count", 32'(n_out), 32'd33);

        send_frame(2, 2, 20);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_edge_valid", 32'(bus.edge_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        m_active = 1'b0; m_row = 0; m_col = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_out = 0;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, int'($urandom_range(0, 15)));
        drain();
        check_eq("no_sof_count", 32'(n_out), 32'd0);
        n_out = 0; send_frame(2, 2, W*H); drain();
        check_eq("post_rst_count", 32'(n_out), 32'd24);

        n_out = 0;
        for (int f = 0; f < 4; f++) send_frame(2, f % 3, W*H);
        drain();
        check_eq("b2b_count", 32'(n_out), 32'd96);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
